// File: rtl/fetch_unit_if.sv
// fetch_unit_if: icache request/response, instruction-queue and redirect signals of the fetch stage.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int FQ_DEPTH   = 4
);
  logic                          icache_req_valid_out;
  logic                          icache_req_ready_in;
  logic [ADDR_WIDTH-1:0]         icache_req_addr_out;
  logic                          icache_resp_valid_in;
  logic [INST_WIDTH-1:0]         icache_resp_inst_in;
  logic                          iq_valid_out;
  logic                          iq_ready_in;
  logic [INST_WIDTH-1:0]         iq_inst_out;
  logic [ADDR_WIDTH-1:0]         iq_pc_out;
  logic                          rob_redirect_in;
  logic [ADDR_WIDTH-1:0]         rob_pc_in;
  logic                          dec_redirect_in;
  logic [ADDR_WIDTH-1:0]         dec_pc_in;
  logic                          bp_redirect_in;
  logic [ADDR_WIDTH-1:0]         bp_pc_in;
  logic [$clog2(FQ_DEPTH):0]     fq_count_out;
  modport master (
    output icache_req_valid_out, icache_req_addr_out, iq_valid_out, iq_inst_out, iq_pc_out, fq_count_out,
    input  icache_req_ready_in, icache_resp_valid_in, icache_resp_inst_in, iq_ready_in,
           rob_redirect_in, rob_pc_in, dec_redirect_in, dec_pc_in, bp_redirect_in, bp_pc_in
  );
  modport slave (
    input  icache_req_valid_out, icache_req_addr_out, iq_valid_out, iq_inst_out, iq_pc_out, fq_count_out,
    output icache_req_ready_in, icache_resp_valid_in, icache_resp_inst_in, iq_ready_in,
           rob_redirect_in, rob_pc_in, dec_redirect_in, dec_pc_in, bp_redirect_in, bp_pc_in
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one icache request at a time into a slot-reserved fetch buffer.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic         clk_in,
  input logic         rst_in,
  input logic         rdy_in,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, req_pc, target;
  logic [INST_WIDTH-1:0] inst_mem [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem [FQ_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic redirect, req_valid, accept, push, pop;
  assign redirect = bus.rob_redirect_in | bus.dec_redirect_in | bus.bp_redirect_in;
  assign target = bus.rob_redirect_in ? bus.rob_pc_in : bus.dec_redirect_in ? bus.dec_pc_in : bus.bp_pc_in;
  always_ff @(posedge clk_in)
    if (rst_in) state <= FETCH;
    else if (rdy_in) state <= state_nxt;
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:   state_nxt = accept ? WAIT : FETCH;
      WAIT:    state_nxt = bus.icache_resp_valid_in ? FETCH : redirect ? DROP : WAIT;
      DROP:    state_nxt = bus.icache_resp_valid_in ? FETCH : DROP;
      default: state_nxt = FETCH;
    endcase
  end
  // a response made stale by a same-cycle redirect is never pushed
  always_comb begin
    req_valid = !rst_in && state == FETCH && count < FULL && !redirect;
    accept    = rdy_in && req_valid && bus.icache_req_ready_in;
    push      = rdy_in && !rst_in && state == WAIT && bus.icache_resp_valid_in && !redirect;
    pop       = rdy_in && count != '0 && bus.iq_ready_in && !redirect;
    bus.icache_req_valid_out = req_valid;
    bus.icache_req_addr_out  = pc;
    bus.iq_valid_out         = count != '0;
    bus.iq_inst_out          = inst_mem[rd_ptr];
    bus.iq_pc_out            = pc_mem[rd_ptr];
    bus.fq_count_out         = count;
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (redirect) begin
        pc     <= target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) begin
          pc     <= pc + ADDR_WIDTH'(4);
          req_pc <= pc;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk_in)
    if (push) begin
      inst_mem[wr_ptr] <= bus.icache_resp_inst_in;
      pc_mem[wr_ptr]   <= req_pc;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch-stage scenarios against a latency-programmable icache model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int passed = 0;
  int total = 0;
  int lat = 1;
  int acc_cnt = 0;
  int acc_base = 0;
  int pop_base = 0;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  always #5 clk = ~clk;
  fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .FQ_DEPTH(4)) bus ();
  fetch_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus)
  );
  // icache: answers the accepted request lat enabled cycles later, frozen by rdy, cleared by rst
  initial begin
    logic r, s, acc, pend;
    logic [31:0] a, paddr;
    int cnt;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    bus.icache_resp_valid_in = 1'b0;
    bus.icache_resp_inst_in = '0;
    forever begin
      @(negedge clk);
      r = rdy;
      s = rst;
      acc = rdy && bus.icache_req_valid_out && bus.icache_req_ready_in;
      a = bus.icache_req_addr_out;
      @(posedge clk);
      #1;
      if (s) begin
        pend = 1'b0;
        bus.icache_resp_valid_in = 1'b0;
      end else if (r) begin
        bus.icache_resp_valid_in = 1'b0;
        if (acc) begin
          pend = 1'b1;
          cnt = lat;
          paddr = a;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.icache_resp_valid_in = 1'b1;
            bus.icache_resp_inst_in = ~paddr;
            pend = 1'b0;
          end
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst && rdy && bus.icache_req_valid_out && bus.icache_req_ready_in) acc_cnt++;
    if (!rst && rdy && bus.iq_valid_out && bus.iq_ready_in &&
        !(bus.rob_redirect_in || bus.dec_redirect_in || bus.bp_redirect_in)) begin
      pop_pc.push_back(bus.iq_pc_out);
      pop_inst.push_back(bus.iq_inst_out);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    #1;
    chk("rst_req_valid", 32'(bus.icache_req_valid_out), 0);
    chk("rst_iq_valid", 32'(bus.iq_valid_out), 0);
    chk("rst_count", 32'(bus.fq_count_out), 0);
    rst = 1'b0;
    pop_base = pop_pc.size();
    acc_base = acc_cnt;
  endtask
  initial begin
    bus.icache_req_ready_in = 1'b1;
    bus.iq_ready_in = 1'b1;
    bus.rob_redirect_in = 1'b0;
    bus.dec_redirect_in = 1'b0;
    bus.bp_redirect_in = 1'b0;
    bus.rob_pc_in = '0;
    bus.dec_pc_in = '0;
    bus.bp_pc_in = '0;
    // in-order streaming with a 1-cycle icache
    do_reset();
    #1;
    chk("t1_req_valid", 32'(bus.icache_req_valid_out), 1);
    chk("t1_req_addr", bus.icache_req_addr_out, 32'h0);
    cyc(7);
    chk("t1_npop", 32'(pop_pc.size() - pop_base), 3);
    chk("t1_pc0", pop_pc[pop_base], 32'h0);
    chk("t1_pc1", pop_pc[pop_base+1], 32'h4);
    chk("t1_pc2", pop_pc[pop_base+2], 32'h8);
    chk("t1_inst2", pop_inst[pop_base+2], ~32'h8);
    // back-pressure fills the buffer then stalls requests
    bus.iq_ready_in = 1'b0;
    do_reset();
    cyc(10);
    chk("t2_count", 32'(bus.fq_count_out), 4);
    chk("t2_req_valid", 32'(bus.icache_req_valid_out), 0);
    chk("t2_nreq", 32'(acc_cnt - acc_base), 4);
    chk("t2_head_pc", bus.iq_pc_out, 32'h0);
    chk("t2_addr", bus.icache_req_addr_out, 32'h10);
    bus.iq_ready_in = 1'b1;
    cyc(1);
    #1;
    chk("t2_resume_valid", 32'(bus.icache_req_valid_out), 1);
    chk("t2_resume_addr", bus.icache_req_addr_out, 32'h10);
    chk("t2_resume_count", 32'(bus.fq_count_out), 3);
    chk("t2_resume_head", bus.iq_pc_out, 32'h4);
    // rob redirect while waiting on 0x8 with a slow icache
    bus.iq_ready_in = 1'b0;
    lat = 3;
    do_reset();
    cyc(9);
    chk("t3_count_pre", 32'(bus.fq_count_out), 2);
    chk("t3_addr_pre", bus.icache_req_addr_out, 32'hC);
    bus.rob_redirect_in = 1'b1;
    bus.rob_pc_in = 32'h100;
    cyc(1);
    bus.rob_redirect_in = 1'b0;
    #1;
    chk("t3_count_flush", 32'(bus.fq_count_out), 0);
    chk("t3_iq_valid", 32'(bus.iq_valid_out), 0);
    chk("t3_drop_noreq", 32'(bus.icache_req_valid_out), 0);
    chk("t3_addr", bus.icache_req_addr_out, 32'h100);
    cyc(1);
    chk("t3_drop_resp_noreq", 32'(bus.icache_req_valid_out), 0);
    cyc(1);
    lat = 1;
    bus.iq_ready_in = 1'b1;
    #1;
    chk("t3_refetch_valid", 32'(bus.icache_req_valid_out), 1);
    chk("t3_stale_not_pushed", 32'(bus.fq_count_out), 0);
    cyc(2);
    chk("t3_head_valid", 32'(bus.iq_valid_out), 1);
    chk("t3_head_pc", bus.iq_pc_out, 32'h100);
    chk("t3_head_inst", bus.iq_inst_out, ~32'h100);
    // redirect priority rob > dec > bp
    do_reset();
    bus.rob_redirect_in = 1'b1;
    bus.rob_pc_in = 32'h200;
    bus.dec_redirect_in = 1'b1;
    bus.dec_pc_in = 32'h300;
    bus.bp_redirect_in = 1'b1;
    bus.bp_pc_in = 32'h400;
    #1;
    chk("t4_noreq", 32'(bus.icache_req_valid_out), 0);
    cyc(1);
    bus.rob_redirect_in = 1'b0;
    #1;
    chk("t4_rob_addr", bus.icache_req_addr_out, 32'h200);
    cyc(1);
    bus.dec_redirect_in = 1'b0;
    #1;
    chk("t4_dec_addr", bus.icache_req_addr_out, 32'h300);
    cyc(1);
    bus.bp_redirect_in = 1'b0;
    #1;
    chk("t4_bp_addr", bus.icache_req_addr_out, 32'h400);
    chk("t4_req_valid", 32'(bus.icache_req_valid_out), 1);
    chk("t4_nreq", 32'(acc_cnt - acc_base), 0);
    // rdy freeze in WAIT and with a buffered head
    lat = 3;
    do_reset();
    cyc(1);
    rdy = 1'b0;
    cyc(5);
    chk("t5_count", 32'(bus.fq_count_out), 0);
    chk("t5_addr", bus.icache_req_addr_out, 32'h4);
    chk("t5_iq_valid", 32'(bus.iq_valid_out), 0);
    chk("t5_req_valid", 32'(bus.icache_req_valid_out), 0);
    rdy = 1'b1;
    cyc(3);
    #1;
    chk("t5_head_valid", 32'(bus.iq_valid_out), 1);
    chk("t5_head_pc", bus.iq_pc_out, 32'h0);
    chk("t5_head_inst", bus.iq_inst_out, ~32'h0);
    chk("t5_next_addr", bus.icache_req_addr_out, 32'h4);
    rdy = 1'b0;
    cyc(3);
    chk("t5_hold_valid", 32'(bus.iq_valid_out), 1);
    chk("t5_hold_count", 32'(bus.fq_count_out), 1);
    chk("t5_hold_pc", bus.iq_pc_out, 32'h0);
    rdy = 1'b1;
    cyc(1);
    chk("t5_pop_count", 32'(bus.fq_count_out), 0);
    chk("t5_pop_addr", bus.icache_req_addr_out, 32'h8);
    chk("t5_wait", 32'(bus.icache_req_valid_out), 0);
    // redirect coinciding with the response, then reset while in DROP
    lat = 1;
    bus.iq_ready_in = 1'b0;
    do_reset();
    cyc(1);
    bus.bp_redirect_in = 1'b1;
    bus.bp_pc_in = 32'h40;
    cyc(1);
    bus.bp_redirect_in = 1'b0;
    #1;
    chk("t6_count", 32'(bus.fq_count_out), 0);
    chk("t6_fetch", 32'(bus.icache_req_valid_out), 1);
    chk("t6_addr", bus.icache_req_addr_out, 32'h40);
    cyc(2);
    chk("t6_head_valid", 32'(bus.iq_valid_out), 1);
    chk("t6_head_pc", bus.iq_pc_out, 32'h40);
    chk("t6_count1", 32'(bus.fq_count_out), 1);
    lat = 3;
    cyc(1);
    bus.dec_redirect_in = 1'b1;
    bus.dec_pc_in = 32'h80;
    cyc(1);
    bus.dec_redirect_in = 1'b0;
    #1;
    chk("t6_drop_noreq", 32'(bus.icache_req_valid_out), 0);
    chk("t6_drop_count", 32'(bus.fq_count_out), 0);
    chk("t6_drop_addr", bus.icache_req_addr_out, 32'h80);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    chk("t6_rst_req", 32'(bus.icache_req_valid_out), 1);
    chk("t6_rst_addr", bus.icache_req_addr_out, 32'h0);
    chk("t6_rst_count", 32'(bus.fq_count_out), 0);
    chk("t6_rst_iq", 32'(bus.iq_valid_out), 0);
    acc_base = acc_cnt;
    cyc(1);
    chk("t6_first_req", 32'(acc_cnt - acc_base), 1);
    chk("t6_wait", 32'(bus.icache_req_valid_out), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
